// File: rtl/rx_tlp_steer_ctrl_if.sv
// Receive-side TLP DW stream plus the duo-buffer (header/data FIFO) write bus.
// master = upstream link layer and buffer status source, slave = steering control.
interface rx_tlp_steer_ctrl_if #(
    parameter int DATA_WIDTH = 32
);
    // Upstream DW stream, no backpressure
    logic                  in_valid;
    logic                  in_sop;
    logic                  in_eop;
    logic                  in_err;
    logic [DATA_WIDTH-1:0] in_dw;

    // Duo-buffer status
    logic                  full_header;
    logic                  full_data;
    logic [9:0]            header_credit;
    logic [9:0]            data_credit;

    // Duo-buffer write side
    logic                  wr_en;
    logic                  header_data;
    logic [DATA_WIDTH-1:0] wr_dw;
    logic                  commit;
    logic                  flush;

    modport master (
        output in_valid, in_sop, in_eop, in_err, in_dw,
        output full_header, full_data, header_credit, data_credit,
        input  wr_en, header_data, wr_dw, commit, flush
    );

    modport slave (
        input  in_valid, in_sop, in_eop, in_err, in_dw,
        input  full_header, full_data, header_credit, data_credit,
        output wr_en, header_data, wr_dw, commit, flush
    );
endinterface

// File: rtl/rx_tlp_steer_ctrl.sv
// Receive TLP steering control: splits each incoming TLP into header and data
// FIFO writes, checks credits up front, and commits or flushes the pending TLP.
module rx_tlp_steer_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    rx_tlp_steer_ctrl_if.slave   bus,
    output logic                 busy,
    output logic [CNT_WIDTH-1:0] good_cnt,
    output logic [CNT_WIDTH-1:0] drop_cnt
);
    typedef enum logic [1:0] { IDLE, HDR, DATA, DROP } state_t;

    state_t                state;
    logic                  has_data_r;
    logic [2:0]            hdr_len_r;
    logic [10:0]           len_r;
    logic [2:0]            hdr_cnt;
    logic [10:0]           data_cnt;
    logic                  commit_pend;
    logic                  flush_pend;

    logic [DATA_WIDTH-1:0] dw;
    logic                  sop_has_data;
    logic [2:0]            sop_hdr_len;
    logic [10:0]           sop_len;
    logic                  credit_ok;
    logic                  in_data;
    logic                  tgt_full;
    logic                  over;
    logic                  last;
    logic                  bad_dw;

    // Saturating add so the statistics stick at all-ones instead of wrapping.
    function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] cnt,
                                                     input logic [1:0]           inc);
        logic [CNT_WIDTH:0] sum;
        sum = {1'b0, cnt} + {{(CNT_WIDTH-1){1'b0}}, inc};
        return sum[CNT_WIDTH] ? '1 : sum[CNT_WIDTH-1:0];
    endfunction

    assign dw = bus.in_dw;

    // SOP field decode; length 0 encodes 1024 DWs
    assign sop_has_data = dw[30];
    assign sop_hdr_len  = 3'd3 + {2'b00, dw[29]};
    assign sop_len      = (dw[9:0] == 10'd0) ? 11'd1024 : {1'b0, dw[9:0]};
    assign credit_ok    = ({7'd0, sop_hdr_len} <= bus.header_credit) &&
                          (!sop_has_data || ({1'b0, bus.data_credit} >= sop_len));

    // Per-DW checks while a TLP is being written (HDR or DATA)
    assign in_data  = (state == DATA);
    assign tgt_full = in_data ? bus.full_data : bus.full_header;
    assign over     = in_data ? (data_cnt >= len_r) : (hdr_cnt >= hdr_len_r);
    assign last     = in_data ? (data_cnt + 11'd1 == len_r) : (hdr_cnt + 3'd1 == hdr_len_r);
    assign bad_dw   = bus.in_err || tgt_full || over;

    assign busy = (state != IDLE);

    // Steering FSM with registered write strobe, commit/flush pipeline and counters
    always_ff @(posedge clk) begin
        // NOTE: the pending commit/flush stage is cleared too, so a TLP cut off by
        // reset never produces a late pulse after release.
        if (rst) begin
            state           <= IDLE;
            has_data_r      <= 1'b0;
            hdr_len_r       <= 3'd0;
            len_r           <= 11'd0;
            hdr_cnt         <= 3'd0;
            data_cnt        <= 11'd0;
            commit_pend     <= 1'b0;
            flush_pend      <= 1'b0;
            bus.wr_en       <= 1'b0;
            bus.header_data <= 1'b0;
            bus.wr_dw       <= '0;
            bus.commit      <= 1'b0;
            bus.flush       <= 1'b0;
            good_cnt        <= '0;
            drop_cnt        <= '0;
        end else begin
            // NOTE: non-blocking throughout; later assignments in this block
            // override these defaults for the cycle.
            bus.wr_en   <= 1'b0;
            commit_pend <= 1'b0;
            flush_pend  <= 1'b0;
            bus.commit  <= commit_pend;
            bus.flush   <= flush_pend;

            if (bus.in_valid) begin
                unique case (state)
                    IDLE: begin
                        if (bus.in_sop) begin
                            has_data_r <= sop_has_data;
                            hdr_len_r  <= sop_hdr_len;
                            len_r      <= sop_len;
                            data_cnt   <= 11'd0;
                            if (bus.in_eop || !credit_ok) begin
                                // Too short to be legal, or no room: drop without writing
                                drop_cnt <= sat_add(drop_cnt, 2'd1);
                                state    <= bus.in_eop ? IDLE : DROP;
                            end else if (bus.in_err || bus.full_header) begin
                                flush_pend <= 1'b1;
                                drop_cnt   <= sat_add(drop_cnt, 2'd1);
                                state      <= DROP;
                            end else begin
                                bus.wr_en       <= 1'b1;
                                bus.header_data <= 1'b0;
                                bus.wr_dw       <= dw;
                                hdr_cnt         <= 3'd1;
                                state           <= HDR;
                            end
                        end
                    end

                    HDR, DATA: begin
                        if (bus.in_sop || bad_dw) begin
                            // A new SOP costs both the pending TLP and the new one
                            flush_pend <= 1'b1;
                            drop_cnt   <= sat_add(drop_cnt, bus.in_sop ? 2'd2 : 2'd1);
                            state      <= bus.in_eop ? IDLE : DROP;
                        end else begin
                            bus.wr_en       <= 1'b1;
                            bus.header_data <= in_data;
                            bus.wr_dw       <= dw;
                            if (in_data) data_cnt <= data_cnt + 11'd1;
                            else         hdr_cnt  <= hdr_cnt + 3'd1;

                            if (bus.in_eop) begin
                                if (last && (in_data || !has_data_r)) begin
                                    commit_pend <= 1'b1;
                                    good_cnt    <= sat_add(good_cnt, 2'd1);
                                end else begin
                                    flush_pend <= 1'b1;
                                    drop_cnt   <= sat_add(drop_cnt, 2'd1);
                                end
                                state <= IDLE;
                            end else if (!in_data && last && has_data_r) begin
                                state <= DATA;
                            end
                        end
                    end

                    DROP: begin
                        if (bus.in_eop) state <= IDLE;
                    end

                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_rx_tlp_steer_ctrl.sv
// Directed bench for rx_tlp_steer_ctrl. Stimulus pushes expected writes and
// commit/flush pulses (with their due cycle) into queues; an independent
// monitor pops and compares whenever the DUT presents an output.
module tb_rx_tlp_steer_ctrl;
    localparam int DW = 32;
    localparam int CW = 4;   // narrow counters so saturation is reachable

    typedef struct packed {
        logic [15:0] cyc;
        logic        hd;
        logic [31:0] dw;
    } wr_exp_t;

    typedef struct packed {
        logic [15:0] cyc;
        logic        commit;
        logic        flush;
    } pulse_exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          busy;
    logic [CW-1:0] good_cnt;
    logic [CW-1:0] drop_cnt;

    int unsigned   cyc = 0;
    int            n_cmp = 0;
    int            n_bad = 0;
    int            exp_good = 0;
    int            exp_drop = 0;
    wr_exp_t       wq[$];
    pulse_exp_t    pq[$];

    rx_tlp_steer_ctrl_if #(.DATA_WIDTH(DW)) bus ();

    rx_tlp_steer_ctrl #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .busy     (busy),
        .good_cnt (good_cnt),
        .drop_cnt (drop_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int sat(input int v);
        return (v > (1 << CW) - 1) ? (1 << CW) - 1 : v;
    endfunction

    function automatic logic [31:0] mk_dw0(input logic has_data, input logic four,
                                           input logic [9:0] len);
        return {1'b0, has_data, four, 19'd0, len};
    endfunction

    // Monitor: every presented write or pulse must match the head of its queue
    always @(negedge clk) begin : monitor
        wr_exp_t    we;
        pulse_exp_t pe;
        if (bus.wr_en === 1'b1) begin
            if (wq.size() != 0) we = wq.pop_front();
            else                we = '1;
            check("wr", 64'({cyc[15:0], bus.header_data, bus.wr_dw}), 64'(we));
        end
        if (bus.commit === 1'b1 || bus.flush === 1'b1) begin
            if (pq.size() != 0) pe = pq.pop_front();
            else                pe = '1;
            check("pulse", 64'({cyc[15:0], bus.commit, bus.flush}), 64'(pe));
        end
    end

    task automatic drive(input logic sop, input logic eop, input logic err, input logic [31:0] d);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b1;
        bus.in_sop   = sop;
        bus.in_eop   = eop;
        bus.in_err   = err;
        bus.in_dw    = d;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            bus.in_valid = 1'b0;
            bus.in_sop   = 1'b0;
            bus.in_eop   = 1'b0;
            bus.in_err   = 1'b0;
        end
    endtask

    // Must be called right after the drive() of the DW concerned
    task automatic exp_wr(input logic hd, input logic [31:0] d);
        wq.push_back('{cyc: 16'(cyc + 1), hd: hd, dw: d});
    endtask

    task automatic exp_pulse(input logic is_commit);
        pq.push_back('{cyc: 16'(cyc + 2), commit: is_commit, flush: !is_commit});
    endtask

    task automatic check_idle(input string tag);
        @(negedge clk);
        check({tag, "_busy"}, 64'(busy), 64'(0));
        check({tag, "_good"}, 64'(good_cnt), 64'(exp_good));
        check({tag, "_drop"}, 64'(drop_cnt), 64'(exp_drop));
    endtask

    // Well-formed TLP: all DWs written, commit two cycles after EOP
    task automatic good_tlp(input logic has_data, input logic four, input logic [9:0] len,
                            input logic [31:0] seed);
        logic [31:0] d;
        d = mk_dw0(has_data, four, len);
        drive(1'b1, 1'b0, 1'b0, d);
        exp_wr(1'b0, d);
        for (int i = 1; i < 3 + int'(four); i++) begin
            d = seed + 32'(i);
            drive(1'b0, !has_data && (i == 2 + int'(four)), 1'b0, d);
            exp_wr(1'b0, d);
        end
        if (has_data) begin
            for (int i = 0; i < int'(len); i++) begin
                d = seed + 32'h0010_0000 + 32'(i);
                drive(1'b0, i == int'(len) - 1, 1'b0, d);
                exp_wr(1'b1, d);
            end
        end
        exp_pulse(1'b1);
        exp_good = sat(exp_good + 1);
    endtask

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        logic [31:0] d;
        bus.in_valid      = 1'b0;
        bus.in_sop        = 1'b0;
        bus.in_eop        = 1'b0;
        bus.in_err        = 1'b0;
        bus.in_dw         = '0;
        bus.full_header   = 1'b0;
        bus.full_data     = 1'b0;
        bus.header_credit = 10'd16;
        bus.data_credit   = 10'd64;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ctrl", 64'({bus.wr_en, bus.header_data, bus.commit, bus.flush, busy}), 64'(0));
        check("rst_wr_dw", 64'(bus.wr_dw), 64'(0));
        check("rst_cnt", 64'({good_cnt, drop_cnt}), 64'(0));
        @(posedge clk);
        #1 rst = 1'b0;

        // 3DW header, no data
        good_tlp(1'b0, 1'b0, 10'd0, 32'h1100_0000);
        idle(4);
        check_idle("s1");

        // 4DW header with 2 data DWs
        good_tlp(1'b1, 1'b1, 10'd2, 32'h2200_0000);
        idle(4);
        check_idle("s2");

        // len=2 but EOP after 1 data DW: written, then flushed
        d = mk_dw0(1'b1, 1'b0, 10'd2);
        drive(1'b1, 1'b0, 1'b0, d);             exp_wr(1'b0, d);
        drive(1'b0, 1'b0, 1'b0, 32'h3300_0001); exp_wr(1'b0, 32'h3300_0001);
        drive(1'b0, 1'b0, 1'b0, 32'h3300_0002); exp_wr(1'b0, 32'h3300_0002);
        drive(1'b0, 1'b1, 1'b0, 32'h3300_0003); exp_wr(1'b1, 32'h3300_0003);
        exp_pulse(1'b0);
        exp_drop = sat(exp_drop + 1);
        idle(4);
        check_idle("s3");

        // Data credit shortfall: whole TLP dropped silently, next TLP commits
        bus.data_credit = 10'd1;
        drive(1'b1, 1'b0, 1'b0, mk_dw0(1'b1, 1'b0, 10'd4));
        drive(1'b0, 1'b0, 1'b0, 32'h4400_0001);
        @(negedge clk);
        check("s4_busy_drop", 64'(busy), 64'(1));
        drive(1'b0, 1'b0, 1'b0, 32'h4400_0002);
        for (int i = 0; i < 4; i++) drive(1'b0, i == 3, 1'b0, 32'h4400_0010 + 32'(i));
        exp_drop = sat(exp_drop + 1);
        idle(2);
        bus.data_credit = 10'd64;
        good_tlp(1'b0, 1'b0, 10'd0, 32'h4500_0000);
        idle(4);
        check_idle("s4");

        // in_err on 2nd header DW of a 5-DW TLP
        d = mk_dw0(1'b1, 1'b1, 10'd1);
        drive(1'b1, 1'b0, 1'b0, d);             exp_wr(1'b0, d);
        drive(1'b0, 1'b0, 1'b1, 32'h5500_0001); exp_pulse(1'b0);
        exp_drop = sat(exp_drop + 1);
        drive(1'b0, 1'b0, 1'b0, 32'h5500_0002);
        @(negedge clk);
        check("s5_busy_drop", 64'(busy), 64'(1));
        drive(1'b0, 1'b0, 1'b0, 32'h5500_0003);
        drive(1'b0, 1'b1, 1'b0, 32'h5500_0004);
        idle(4);
        check_idle("s5");

        // SOP together with EOP: dropped, nothing written
        drive(1'b1, 1'b1, 1'b0, mk_dw0(1'b0, 1'b0, 10'd0));
        exp_drop = sat(exp_drop + 1);
        idle(4);
        check_idle("s7");

        // SOP arriving mid-header: pending flushed plus new TLP dropped
        d = mk_dw0(1'b0, 1'b0, 10'd0);
        drive(1'b1, 1'b0, 1'b0, d);             exp_wr(1'b0, d);
        drive(1'b0, 1'b0, 1'b0, 32'h7700_0001); exp_wr(1'b0, 32'h7700_0001);
        drive(1'b1, 1'b0, 1'b0, d);             exp_pulse(1'b0);
        exp_drop = sat(exp_drop + 2);
        drive(1'b0, 1'b0, 1'b0, 32'h7700_0002);
        drive(1'b0, 1'b1, 1'b0, 32'h7700_0003);
        idle(4);
        check_idle("s8");

        // Stray non-SOP DWs in IDLE are ignored
        drive(1'b0, 1'b1, 1'b0, 32'hDEAD_BEEF);
        drive(1'b0, 1'b0, 1'b0, 32'h4000_0003);
        idle(4);
        check_idle("s9");

        // Reset asserted mid-DATA: no pulse, everything cleared, then normal TLP
        d = mk_dw0(1'b1, 1'b0, 10'd4);
        drive(1'b1, 1'b0, 1'b0, d);             exp_wr(1'b0, d);
        drive(1'b0, 1'b0, 1'b0, 32'h6600_0001); exp_wr(1'b0, 32'h6600_0001);
        drive(1'b0, 1'b0, 1'b0, 32'h6600_0002); exp_wr(1'b0, 32'h6600_0002);
        drive(1'b0, 1'b0, 1'b0, 32'h6600_0010); exp_wr(1'b1, 32'h6600_0010);
        drive(1'b0, 1'b0, 1'b0, 32'h6600_0011);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        exp_good = 0;
        exp_drop = 0;
        check("s6_rst_ctrl", 64'({bus.wr_en, bus.header_data, bus.commit, bus.flush, busy}), 64'(0));
        check("s6_rst_wr_dw", 64'(bus.wr_dw), 64'(0));
        check("s6_rst_cnt", 64'({good_cnt, drop_cnt}), 64'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.in_valid = 1'b0;
        good_tlp(1'b0, 1'b0, 10'd0, 32'h6700_0000);
        idle(4);
        check_idle("s6");

        // drop_cnt saturation, including a +2 step across the ceiling
        for (int i = 0; i < 14; i++) begin
            drive(1'b1, 1'b1, 1'b0, mk_dw0(1'b0, 1'b0, 10'd0));
            exp_drop = sat(exp_drop + 1);
        end
        idle(3);
        check_idle("sat14");
        d = mk_dw0(1'b0, 1'b0, 10'd0);
        drive(1'b1, 1'b0, 1'b0, d);             exp_wr(1'b0, d);
        drive(1'b0, 1'b0, 1'b0, 32'h8800_0001); exp_wr(1'b0, 32'h8800_0001);
        drive(1'b1, 1'b0, 1'b0, d);             exp_pulse(1'b0);
        exp_drop = sat(exp_drop + 2);
        drive(1'b0, 1'b1, 1'b0, 32'h8800_0002);
        idle(4);
        check_idle("sat_step2");
        drive(1'b1, 1'b1, 1'b0, d);
        exp_drop = sat(exp_drop + 1);
        idle(3);
        check_idle("sat_hold");

        // Nothing expected may be left unseen
        idle(3);
        check("wq_left", 64'(wq.size()), 64'(0));
        check("pq_left", 64'(pq.size()), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
